// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF/ID pipeline register with valid/ready handshake, two-entry skid buffer,
// bubble-inserting flush and a saturating stall-cycle counter.
module if_id_skid_reg #(
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013),
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] dout,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] pc_plus4,
    input  logic                  pred_taken,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] instr_d,
    output logic [DATA_WIDTH-1:0] pc_d,
    output logic [DATA_WIDTH-1:0] pc_plus4_d,
    output logic                  pred_taken_d,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);
    localparam int PW = 3 * DATA_WIDTH + 1;
    localparam logic [PW-1:0] NOP_PL = {NOP_INSTR, {(2 * DATA_WIDTH + 1){1'b0}}};

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         main_q, main_d, skid_q, skid_d;
    logic [CNT_WIDTH-1:0]  stall_q, stall_d;
    logic [PW-1:0]         in_pl;
    logic                  in_fire, out_fire;

    assign in_pl     = {dout, pc, pc_plus4, pred_taken};
    assign in_ready  = state_q != TWO;
    assign out_valid = state_q != EMPTY;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign {instr_d, pc_d, pc_plus4_d, pred_taken_d} = main_q;
    assign stall_cnt = stall_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = NOP_PL;
            skid_d  = NOP_PL;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) begin
                    main_d  = in_pl;
                    state_d = ONE;
                end
                ONE: if (in_fire && out_fire) begin
                    main_d = in_pl;
                end else if (out_fire) begin
                    main_d  = NOP_PL;
                    state_d = EMPTY;
                end else if (in_fire) begin
                    skid_d  = in_pl;
                    state_d = TWO;
                end
                TWO: if (out_fire) begin
                    main_d  = skid_q;
                    skid_d  = NOP_PL;
                    state_d = ONE;
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = NOP_PL;
                    skid_d  = NOP_PL;
                end
            endcase
        end
        // Counts stalls even across flush-free holds; saturates instead of wrapping
        stall_d = (out_valid && !out_ready && !flush && stall_q != '1) ? stall_q + CNT_WIDTH'(1) : stall_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= NOP_PL;
            skid_q  <= NOP_PL;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end
endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb_if_id_skid_reg: vector table, corner-case sequences and random traffic against a queue model.
module tb_if_id_skid_reg;
    logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0, pred_taken = 0;
    logic [31:0] dout = 0, pc = 0, pc_plus4 = 0;
    logic        in_ready, out_valid, pred_taken_d;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic [15:0] stall_cnt;
    logic        s_in_ready, s_out_valid, s_pred_taken_d;
    logic [31:0] s_instr_d, s_pc_d, s_pc_plus4_d;
    logic [2:0]  s_stall_cnt;

    if_id_skid_reg dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .dout(dout), .pc(pc), .pc_plus4(pc_plus4), .pred_taken(pred_taken),
        .out_valid(out_valid), .out_ready(out_ready), .instr_d(instr_d), .pc_d(pc_d),
        .pc_plus4_d(pc_plus4_d), .pred_taken_d(pred_taken_d), .stall_cnt(stall_cnt)
    );

    if_id_skid_reg #(.CNT_WIDTH(3)) dut_s (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .dout(dout), .pc(pc), .pc_plus4(pc_plus4), .pred_taken(pred_taken),
        .out_valid(s_out_valid), .out_ready(out_ready), .instr_d(s_instr_d), .pc_d(s_pc_d),
        .pc_plus4_d(s_pc_plus4_d), .pred_taken_d(s_pred_taken_d), .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    typedef struct {
        logic        fl, iv, orr;
        logic [31:0] instr, pc;
        logic        pred;
        logic        e_v, e_r;
        logic [31:0] e_instr, e_pc;
        logic        e_pred;
        int          e_stall;
    } vec_t;

    ent_t q[$];
    int   m_stall, m_stall_s;
    int   tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic fl, input logic iv, input logic orr,
                         input logic [31:0] ins, input logic [31:0] pcv, input logic pr);
        logic ifire, ofire, stl;
        flush = fl; in_valid = iv; out_ready = orr;
        dout = ins; pc = pcv; pc_plus4 = pcv + 32'd4; pred_taken = pr;
        ifire = iv && q.size() < 2;
        ofire = orr && q.size() > 0;
        stl   = q.size() > 0 && !orr && !fl;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (ofire) void'(q.pop_front());
            if (ifire) q.push_back(ent_t'{ins, pcv, pr});
        end
        if (stl) begin
            m_stall   = m_stall < 65535 ? m_stall + 1 : 65535;
            m_stall_s = m_stall_s < 7 ? m_stall_s + 1 : 7;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        logic v;
        ent_t e;
        v = q.size() > 0;
        e = v ? q[0] : ent_t'{32'h13, 32'h0, 1'b0};
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        check({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < 2));
        check({tag, ".instr_d"}, instr_d, e.instr);
        check({tag, ".pc_d"}, pc_d, e.pc);
        check({tag, ".pc_plus4_d"}, pc_plus4_d, v ? e.pc + 32'd4 : 32'd0);
        check({tag, ".pred_taken_d"}, 32'(pred_taken_d), 32'(e.pred));
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
        check({tag, ".stall_cnt_w3"}, 32'(s_stall_cnt), 32'(m_stall_s));
    endtask

    task automatic do_reset();
        rst = 1; flush = 0; in_valid = 0; out_ready = 0;
        q.delete(); m_stall = 0; m_stall_s = 0;
        @(posedge clk);
        #1 rst = 0;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b1, 32'hA0, 32'h00, 1'b0, 1'b1, 1'b1, 32'hA0, 32'h00, 1'b0, 0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'hA1, 32'h04, 1'b0, 1'b1, 1'b1, 32'hA1, 32'h04, 1'b0, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'hA2, 32'h08, 1'b0, 1'b1, 1'b1, 32'hA2, 32'h08, 1'b0, 0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 32'hFF, 32'hFC, 1'b0, 1'b1, 1'b1, 32'hA2, 32'h08, 1'b0, 1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'hA3, 32'h0C, 1'b1, 1'b1, 1'b0, 32'hA2, 32'h08, 1'b0, 2};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'hA4, 32'h10, 1'b0, 1'b1, 1'b0, 32'hA2, 32'h08, 1'b0, 3};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 32'hFF, 32'hFC, 1'b0, 1'b1, 1'b1, 32'hA3, 32'h0C, 1'b1, 3};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 32'hFF, 32'hFC, 1'b0, 1'b0, 1'b1, 32'h13, 32'h00, 1'b0, 3};

        do_reset();
        check_model("reset");

        foreach (vecs[i]) begin
            cycle(vecs[i].fl, vecs[i].iv, vecs[i].orr, vecs[i].instr, vecs[i].pc, vecs[i].pred);
            check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_v));
            check($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_r));
            check($sformatf("vec%0d.instr_d", i), instr_d, vecs[i].e_instr);
            check($sformatf("vec%0d.pc_d", i), pc_d, vecs[i].e_pc);
            check($sformatf("vec%0d.pc_plus4_d", i), pc_plus4_d, vecs[i].e_v ? vecs[i].e_pc + 32'd4 : 32'd0);
            check($sformatf("vec%0d.pred_taken_d", i), 32'(pred_taken_d), 32'(vecs[i].e_pred));
            check($sformatf("vec%0d.stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].e_stall));
        end

        // Asynchronous reset while holding two entries
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 32'hC0, 32'h20, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 32'hC1, 32'h24, 1'b0);
        check("two.in_ready", 32'(in_ready), 32'd0);
        check("two.stall_cnt", 32'(stall_cnt), 32'd1);
        #2 rst = 1;
        #1;
        check("arst.out_valid", 32'(out_valid), 32'd0);
        check("arst.in_ready", 32'(in_ready), 32'd1);
        check("arst.instr_d", instr_d, 32'h13);
        check("arst.pc_d", pc_d, 32'h0);
        check("arst.stall_cnt", 32'(stall_cnt), 32'd0);
        do_reset();
        cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        check_model("arst_after");

        // Flush colliding with input and output handshakes while full
        cycle(1'b0, 1'b1, 1'b0, 32'hB0, 32'h100, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 32'hB1, 32'h104, 1'b0);
        check("fl.pre_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 32'hB2, 32'h108, 1'b1);
        check("fl.out_valid", 32'(out_valid), 32'd0);
        check("fl.instr_d", instr_d, 32'h13);
        check("fl.pc_d", pc_d, 32'h0);
        check("fl.in_ready", 32'(in_ready), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        check("fl.after_valid", 32'(out_valid), 32'd0);
        check("fl.after_instr", instr_d, 32'h13);

        // Stall counter: five stalls survive a flush; long stall saturates the narrow counter
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 32'hD0, 32'h200, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("st5.stall_cnt", 32'(stall_cnt), 32'd5);
        check("st5.stall_cnt_w3", 32'(s_stall_cnt), 32'd5);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("st5.after_flush", 32'(stall_cnt), 32'd5);
        cycle(1'b0, 1'b1, 1'b0, 32'hD1, 32'h204, 1'b0);
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("st10.stall_cnt", 32'(stall_cnt), 32'd15);
        check("st10.stall_cnt_w3", 32'(s_stall_cnt), 32'd7);

        // Prediction bit travels with its PC through the skid slot
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 32'hE0, 32'h40, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 32'hE1, 32'h44, 1'b0);
        check("pred.first_pc", pc_d, 32'h40);
        check("pred.first_bit", 32'(pred_taken_d), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        check("pred.second_pc", pc_d, 32'h44);
        check("pred.second_bit", 32'(pred_taken_d), 32'd0);
        check("pred.second_instr", instr_d, 32'hE1);

        // Random traffic against the queue model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 15) == 0, 1'($urandom), $urandom_range(0, 3) != 0 && k % 50 > 10,
                  $urandom, $urandom & 32'hFFFF_FFFC, 1'($urandom));
            check_model($sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
